// File: rtl/tlul_sram_resp_pkg.sv
// Shared types for the TL-UL SRAM responder.
// Response entry layout, TL-UL channel structs and opcode helpers.
package tlul_sram_resp_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;
    localparam logic [13:0] TL_D_USER_DEFAULT = 14'h0;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [13:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  size;
        logic [7:0]  source;
        logic [31:0] data;
        logic        error;
    } rsp_entry_t;

    function automatic logic opcode_valid(logic [2:0] op);
        return (op == PutFullData) || (op == PutPartialData) || (op == Get);
    endfunction

endpackage

// File: rtl/tlul_sram_resp_fifo.sv
// In-order response queue for the TL-UL SRAM responder.
// Synchronous FIFO of rsp_entry_t with sync active-high reset.
import tlul_sram_resp_pkg::*;

module tlul_sram_resp_fifo #(
    parameter int Depth = 2,
    parameter int PW = (Depth > 1) ? $clog2(Depth) : 1,
    parameter int CW = $clog2(Depth + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push,
    input  rsp_entry_t    wdata,
    input  logic          pop,
    output rsp_entry_t    rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    rsp_entry_t     mem [Depth];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;

    function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
        return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= nxt(wptr);
            if (pop)  rptr <= nxt(rptr);
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == CW'(Depth));
    assign empty = (count == '0);

endmodule

// File: rtl/tlul_sram_resp.sv
// TL-UL responder backed by a word array, in-order 1-cycle responses.
// Optional address checking enabled by TLUL_SRAM_RESP_ADDR_CHK_EN.
import tlul_sram_resp_pkg::*;

module tlul_sram_resp #(
    parameter int          Depth       = 1024,
    parameter int          Outstanding = 2,
    parameter logic [31:0] BaseAddr    = 32'h0,
    parameter int          AW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  tl_h2d_t       tl_i,
    output tl_d2h_t       tl_o,
    input  logic          pl_we_i,
    input  logic [AW-1:0] pl_addr_i,
    input  logic [31:0]   pl_wdata_i
);

    localparam int CW = $clog2(Outstanding + 1);

    logic [31:0]   mem [Depth];
    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          addr_err;
    logic          op_ok;
    logic          err;
    logic          is_get;
    logic          a_ready;
    logic          acc;
    logic          wr_en;
    rsp_entry_t    push_e;
    rsp_entry_t    head;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          d_valid;
    logic          pop;

    assign off = tl_i.a_address - BaseAddr;
    assign idx = AW'((off >> 2) % 32'(Depth));

`ifdef TLUL_SRAM_RESP_ADDR_CHK_EN
    assign addr_err = (off >= 32'(4 * Depth))
                   || (tl_i.a_size == 2'd2 && tl_i.a_address[1:0] != 2'b00)
                   || (tl_i.a_size == 2'd3);
`else
    assign addr_err = 1'b0;
`endif

    assign op_ok   = opcode_valid(tl_i.a_opcode);
    assign err     = !op_ok || addr_err;
    assign is_get  = op_ok && (tl_i.a_opcode == Get);
    assign a_ready = !rst_i && !pl_we_i && !full && (count < CW'(Outstanding));
    assign acc     = tl_i.a_valid && a_ready;
    assign wr_en   = acc && !err && !is_get;

    // Preload and A-channel writes never coincide: preload drops a_ready.
    always_ff @(posedge clk_i) begin
        if (pl_we_i) begin
            mem[pl_addr_i] <= pl_wdata_i;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (tl_i.a_opcode == PutFullData || tl_i.a_mask[b])
                    mem[idx][8*b +: 8] <= tl_i.a_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        push_e        = '0;
        push_e.opcode = is_get ? AccessAckData : AccessAck;
        push_e.size   = tl_i.a_size;
        push_e.source = tl_i.a_source;
        push_e.error  = err;
        if (is_get) push_e.data = err ? ERR_DATA : mem[idx];
    end

    assign d_valid = !rst_i && !empty;
    assign pop     = d_valid && tl_i.d_ready;

    tlul_sram_resp_fifo #(
        .Depth (Outstanding)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (acc),
        .wdata (push_e),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        tl_o         = '0;
        tl_o.d_user  = TL_D_USER_DEFAULT;
        tl_o.a_ready = a_ready;
        if (d_valid) begin
            tl_o.d_valid  = 1'b1;
            tl_o.d_opcode = head.opcode;
            tl_o.d_size   = head.size;
            tl_o.d_source = head.source;
            tl_o.d_data   = head.data;
            tl_o.d_error  = head.error;
        end
    end

endmodule

// File: tb/tb_tlul_sram_resp.sv
// Directed bench for tlul_sram_resp (Depth 1024, Outstanding 2).
// Expectations follow TLUL_SRAM_RESP_ADDR_CHK_EN when defined.
import tlul_sram_resp_pkg::*;

module tb_tlul_sram_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o;
    logic        pl_we = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_wdata = '0;

    int total = 0;
    int bad = 0;

    tlul_sram_resp #(
        .Depth       (1024),
        .Outstanding (2),
        .BaseAddr    (32'h0)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .tl_i       (tl_i),
        .tl_o       (tl_o),
        .pl_we_i    (pl_we),
        .pl_addr_i  (pl_addr),
        .pl_wdata_i (pl_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pl_we = 1'b1;
        pl_addr = a;
        pl_wdata = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic send_a(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] mask,
                          input logic [7:0] src);
        int n = 0;
        tl_i.a_valid = 1'b1;
        tl_i.a_opcode = op;
        tl_i.a_size = 2'd2;
        tl_i.a_source = src;
        tl_i.a_address = addr;
        tl_i.a_mask = mask;
        tl_i.a_data = data;
        #1;
        while (!tl_o.a_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("a_ready_wait", {31'b0, tl_o.a_ready}, 32'd1);
        @(posedge clk); #1;
        tl_i.a_valid = 1'b0;
    endtask

    task automatic expect_d(input string tag, input logic [2:0] op,
                            input logic [31:0] data, input logic [7:0] src,
                            input logic err);
        int n = 0;
        while (!tl_o.d_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_valid"}, {31'b0, tl_o.d_valid}, 32'd1);
        check({tag, "_op"}, {29'b0, tl_o.d_opcode}, {29'b0, op});
        check({tag, "_data"}, tl_o.d_data, data);
        check({tag, "_src"}, {24'b0, tl_o.d_source}, {24'b0, src});
        check({tag, "_err"}, {31'b0, tl_o.d_error}, {31'b0, err});
        check({tag, "_size"}, {30'b0, tl_o.d_size}, 32'd2);
        tl_i.d_ready = 1'b1;
        @(posedge clk); #1;
        tl_i.d_ready = 1'b0;
    endtask

    initial begin
        tl_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_ready", {31'b0, tl_o.a_ready}, 32'd0);
        check("rst_d_valid", {31'b0, tl_o.d_valid}, 32'd0);
        check("rst_d_user", {18'b0, tl_o.d_user}, {18'b0, TL_D_USER_DEFAULT});
        check("rst_d_data", tl_o.d_data, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_a_ready", {31'b0, tl_o.a_ready}, 32'd1);

        pl_we = 1'b1;
        #1;
        check("pl_blocks_a_ready", {31'b0, tl_o.a_ready}, 32'd0);
        pl_we = 1'b0;
        preload(10'h20, 32'h0000_0013);
        preload(10'h10, 32'h1122_3344);
        preload(10'h000, 32'hCAFE_0000);
        preload(10'h30, 32'hA000_000A);
        preload(10'h31, 32'hB000_000B);
        preload(10'h32, 32'hC000_000C);

        // Get returns preloaded word one cycle after acceptance.
        send_a(Get, 32'h80, 32'h0, 4'hF, 8'd3);
        check("t1_latency", {31'b0, tl_o.d_valid}, 32'd1);
        expect_d("t1", AccessAckData, 32'h0000_0013, 8'd3, 1'b0);

        send_a(PutPartialData, 32'h40, 32'hAABB_CCDD, 4'b0011, 8'd7);
        expect_d("t2_put", AccessAck, 32'h0, 8'd7, 1'b0);
        send_a(Get, 32'h40, 32'h0, 4'hF, 8'd8);
        expect_d("t2_get", AccessAckData, 32'h1122_CCDD, 8'd8, 1'b0);

        send_a(PutFullData, 32'h44, 32'hDEAD_BEEF, 4'hF, 8'd9);
        expect_d("tf_put", AccessAck, 32'h0, 8'd9, 1'b0);
        send_a(Get, 32'h44, 32'h0, 4'hF, 8'd10);
        expect_d("tf_get", AccessAckData, 32'hDEAD_BEEF, 8'd10, 1'b0);

        // Backpressure: two in flight, third held off until a pop.
        tl_i.d_ready = 1'b0;
        tl_i.a_valid = 1'b1;
        tl_i.a_opcode = Get;
        tl_i.a_size = 2'd2;
        tl_i.a_mask = 4'hF;
        tl_i.a_address = 32'hC0;
        tl_i.a_source = 8'd1;
        @(posedge clk); #1;
        tl_i.a_address = 32'hC4;
        tl_i.a_source = 8'd2;
        @(posedge clk); #1;
        check("t3_full_a_ready", {31'b0, tl_o.a_ready}, 32'd0);
        tl_i.a_address = 32'hC8;
        tl_i.a_source = 8'd4;
        check("t3_head0", tl_o.d_data, 32'hA000_000A);
        @(posedge clk); #1;
        check("t3_stall_a_ready", {31'b0, tl_o.a_ready}, 32'd0);
        check("t3_stable", tl_o.d_data, 32'hA000_000A);
        check("t3_stable_src", {24'b0, tl_o.d_source}, 32'd1);
        tl_i.d_ready = 1'b1;
        #1;
        check("t3_no_bypass", {31'b0, tl_o.a_ready}, 32'd0);
        @(posedge clk); #1;
        tl_i.d_ready = 1'b0;
        check("t3_after_pop_a_ready", {31'b0, tl_o.a_ready}, 32'd1);
        check("t3_head1", tl_o.d_data, 32'hB000_000B);
        @(posedge clk); #1;
        tl_i.a_valid = 1'b0;
        check("t3_refull", {31'b0, tl_o.a_ready}, 32'd0);
        expect_d("t3_r1", AccessAckData, 32'hB000_000B, 8'd2, 1'b0);
        expect_d("t3_r2", AccessAckData, 32'hC000_000C, 8'd4, 1'b0);

        send_a(3'h7, 32'h40, 32'h5555_5555, 4'hF, 8'd5);
        expect_d("t4_bad", AccessAck, 32'h0, 8'd5, 1'b1);
        send_a(Get, 32'h40, 32'h0, 4'hF, 8'd6);
        expect_d("t4_get", AccessAckData, 32'h1122_CCDD, 8'd6, 1'b0);

        send_a(Get, 32'h1000, 32'h0, 4'hF, 8'd11);
`ifdef TLUL_SRAM_RESP_ADDR_CHK_EN
        expect_d("t5_oob", AccessAckData, 32'hFFFF_FFFF, 8'd11, 1'b1);
`else
        expect_d("t5_wrap", AccessAckData, 32'hCAFE_0000, 8'd11, 1'b0);
`endif

        // Reset with two responses pending drops them.
        tl_i.d_ready = 1'b0;
        send_a(Get, 32'h80, 32'h0, 4'hF, 8'd12);
        send_a(Get, 32'hC0, 32'h0, 4'hF, 8'd13);
        check("t6_pending", {31'b0, tl_o.d_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t6_flushed", {31'b0, tl_o.d_valid}, 32'd0);
        check("t6_a_ready", {31'b0, tl_o.a_ready}, 32'd1);
        send_a(Get, 32'h80, 32'h0, 4'hF, 8'd14);
        expect_d("t6_get", AccessAckData, 32'h0000_0013, 8'd14, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
